// File: rtl/comm_query.sv
// UART query/response sequencer: sends one query byte, waits for a reply,
// retransmitting on timeout until the retry budget is spent.
module comm_query #(
    parameter logic [7:0] QUERY_BYTE   = 8'h3F,
    parameter logic [7:0] EXPECT_BYTE  = 8'h46,
    parameter int         TIMEOUT_CLKS = 50000,
    parameter int         MAX_RETRIES  = 3
) (
    input  logic       CLK_50,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    output logic       o_Busy,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    input  logic       i_TX_Active,
    input  logic       i_TX_Done,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic [7:0] o_Resp_Byte,
    output logic       o_Resp_Valid,
    output logic       o_Match,
    output logic       o_Timeout,
    output logic [3:0] o_Retry_Count
);

    localparam int              CntW     = $clog2(TIMEOUT_CLKS);
    localparam logic [CntW-1:0] CntLast  = CntW'(TIMEOUT_CLKS - 1);
    localparam logic [3:0]      RetryMax = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        SEND,
        WAIT_DONE,
        WAIT_RESP
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [CntW-1:0] count;
    logic            doStart;
    logic            doClear;
    logic            doCapture;
    logic            doRetry;
    logic            doTimeout;

    always_comb begin
        stateNext = state;
        doStart   = 1'b0;
        doClear   = 1'b0;
        doCapture = 1'b0;
        doRetry   = 1'b0;
        doTimeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_Start) begin
                    stateNext = WAIT_READY;
                    doStart   = 1'b1;
                end
            end
            WAIT_READY: begin
                if (!i_TX_Active) stateNext = SEND;
            end
            SEND: stateNext = WAIT_DONE;
            WAIT_DONE: begin
                if (i_TX_Done) begin
                    stateNext = WAIT_RESP;
                    doClear   = 1'b1;
                end
            end
            WAIT_RESP: begin
                // A reply arriving on the expiry cycle still counts
                if (i_RX_DV) begin
                    stateNext = IDLE;
                    doCapture = 1'b1;
                end else if (count == CntLast) begin
                    if (o_Retry_Count < RetryMax) begin
                        stateNext = WAIT_READY;
                        doRetry   = 1'b1;
                    end else begin
                        stateNext = IDLE;
                        doTimeout = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= IDLE;
            count         <= '0;
            o_Retry_Count <= 4'd0;
            o_Resp_Byte   <= 8'h00;
            o_Resp_Valid  <= 1'b0;
            o_Match       <= 1'b0;
            o_Timeout     <= 1'b0;
        end else begin
            state        <= stateNext;
            o_Resp_Valid <= doCapture;
            o_Timeout    <= doTimeout;
            if (doClear) begin
                count <= '0;
            end else if (state == WAIT_RESP) begin
                count <= count + CntW'(1);
            end
            if (doStart) begin
                o_Retry_Count <= 4'd0;
            end else if (doRetry) begin
                o_Retry_Count <= o_Retry_Count + 4'd1;
            end
            if (doCapture) begin
                o_Resp_Byte <= i_RX_Byte;
                o_Match     <= (i_RX_Byte == EXPECT_BYTE);
            end
        end
    end

    assign o_Busy    = (state != IDLE);
    assign o_TX_DV   = (state == SEND);
    assign o_TX_Byte = QUERY_BYTE;

endmodule

// File: doc/comm_query.md
COMM_QUERY -- requirements
Module: comm_query

Interface
REQ-001 The block SHALL have parameter QUERY_BYTE, default 8'h3F ('?'), meaning the byte transmitted as a query.
REQ-002 The block SHALL have parameter EXPECT_BYTE, default 8'h46 ('F'), meaning the reply byte counted as a match.
REQ-003 The block SHALL have parameter TIMEOUT_CLKS, default 50000 (1 ms at 50 MHz), meaning the reply wait per attempt in clocks (>=2).
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3, meaning the retransmissions after the first attempt (0..15).
REQ-005 CLK_50  input  1  system clock; all logic on rising edge.
REQ-006 i_Rst_L  input  1  asynchronous, active-low reset.
REQ-007 i_Start  input  1  request one query transaction; sampled on clock edge.
REQ-008 o_Busy  output  1  high whenever state is not IDLE.
REQ-009 o_TX_DV  output  1  one-cycle transmit strobe to the UART transmitter.
REQ-010 o_TX_Byte  output  8  byte for the UART transmitter.
REQ-011 i_TX_Active  input  1  UART transmitter busy.
REQ-012 i_TX_Done  input  1  one-cycle UART transmitter completion pulse.
REQ-013 i_RX_DV  input  1  one-cycle UART receiver byte-valid pulse.
REQ-014 i_RX_Byte  input  8  UART receiver byte; valid when i_RX_DV high.
REQ-015 o_Resp_Byte  output  8  last captured reply byte; held until the next capture.
REQ-016 o_Resp_Valid  output  1  one-cycle pulse: reply captured.
REQ-017 o_Match  output  1  o_Resp_Byte==EXPECT_BYTE; updated with o_Resp_Valid, held.
REQ-018 o_Timeout  output  1  one-cycle pulse: all attempts exhausted.
REQ-019 o_Retry_Count  output  4  retransmissions used in the current or last transaction.

Function
REQ-020 The FSM SHALL have states IDLE, WAIT_READY, SEND, WAIT_DONE, WAIT_RESP, each registered.
REQ-021 In IDLE, i_Start=1 SHALL move to WAIT_READY and clear o_Retry_Count to 0; i_Start in any other state SHALL be ignored.
REQ-022 In WAIT_READY, i_TX_Active=0 SHALL move to SEND; otherwise the FSM SHALL stay in WAIT_READY.
REQ-023 In SEND, o_TX_DV SHALL be 1 for exactly that one cycle, then the FSM SHALL move to WAIT_DONE; o_TX_DV SHALL be 0 in all other states.
REQ-024 o_TX_Byte SHALL equal QUERY_BYTE at all times after reset.
REQ-025 In WAIT_DONE, i_TX_Done=1 SHALL move to WAIT_RESP and clear the timeout counter to 0.
REQ-026 In WAIT_RESP, the counter SHALL increment by 1 per clock, using width ceil(log2(TIMEOUT_CLKS)).
REQ-027 In WAIT_RESP, i_RX_DV=1 SHALL capture i_RX_Byte into o_Resp_Byte, set o_Match, pulse o_Resp_Valid on the next cycle and return to IDLE.
REQ-028 In WAIT_RESP, counter==TIMEOUT_CLKS-1 with no i_RX_DV and o_Retry_Count<MAX_RETRIES SHALL increment o_Retry_Count and move to WAIT_READY.
REQ-029 In WAIT_RESP, counter==TIMEOUT_CLKS-1 with no i_RX_DV and o_Retry_Count==MAX_RETRIES SHALL pulse o_Timeout on the next cycle and return to IDLE.
REQ-030 If i_RX_DV and timeout expiry coincide, the reply SHALL win (REQ-027); no retry and no o_Timeout.
REQ-031 i_RX_DV outside WAIT_RESP (unsolicited or late byte) SHALL be ignored; o_Resp_Byte, o_Match and o_Resp_Valid are unchanged.
REQ-032 o_Resp_Valid and o_Timeout SHALL never assert in the same cycle.
REQ-033 Latency: with i_TX_Active=0, o_TX_DV SHALL be high in the 2nd cycle after the edge sampling i_Start.

Reset
REQ-034 i_Rst_L=0 SHALL immediately, without a clock, force state IDLE, counter 0, o_Retry_Count 0, o_TX_DV 0, o_Resp_Byte 8'h00, o_Resp_Valid 0, o_Match 0, o_Timeout 0, o_Busy 0.
REQ-035 Reset mid-transaction SHALL abort it with no pending pulses; after release, the block SHALL accept i_Start normally.

Verification (TIMEOUT_CLKS=100, MAX_RETRIES=2)
REQ-036 Start, TX idle, i_TX_Done 10 clks after strobe, RX 8'h46 after 20 clks -> one o_TX_DV with byte 8'h3F, o_Resp_Valid=1, o_Resp_Byte=8'h46, o_Match=1, o_Retry_Count=0.
REQ-037 Start, reply 8'h41 -> o_Resp_Valid=1, o_Match=0, o_Resp_Byte=8'h41.
REQ-038 Start, no RX ever -> exactly 3 o_TX_DV strobes, each 100 clks after the prior i_TX_Done, then o_Timeout pulse, o_Retry_Count=2, o_Busy=0.
REQ-039 i_TX_Active held high 50 clks after Start -> o_TX_DV stays 0 until the cycle after i_TX_Active falls; i_Start pulses while busy cause no second strobe.
REQ-040 i_RX_DV in the same cycle the counter hits 99 on the final attempt -> o_Resp_Valid=1, o_Timeout never 1; a later stray i_RX_DV in IDLE leaves outputs unchanged.
REQ-041 Assert i_Rst_L=0 during WAIT_RESP -> all outputs at reset values within the same cycle; release then Start -> normal transaction per REQ-036.
